// File: rtl/serial_frame_receiver_pkg.sv
// Shared definitions for the two-wire serial frame link (sender, receiver and their benches).
package serial_frame_receiver_pkg;

  localparam int DEFAULT_WIDTH          = 8;
  localparam int DEFAULT_TIMEOUT_CYCLES = 64;
  localparam int DEFAULT_SYNC_STAGES    = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } rxStateT;

endpackage

// File: rtl/serial_frame_receiver_if.sv
// Consumer-side bundle of the frame receiver: holding-buffer handshake and error reporting.
interface serial_frame_receiver_if
  import serial_frame_receiver_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0] dataOut;
  logic             dataValid;
  logic             dataAccept;
  logic             overrun;
  logic             frameError;
  logic             clearErrors;

  modport master (
    output dataOut,
    output dataValid,
    output overrun,
    output frameError,
    input  dataAccept,
    input  clearErrors
  );

  modport slave (
    input  dataOut,
    input  dataValid,
    input  overrun,
    input  frameError,
    output dataAccept,
    output clearErrors
  );

endinterface

// File: rtl/sync_edge_detect.sv
// Resynchronises serialClock/serialData into the local domain and flags serialClock rising edges
// together with the data bit captured through the same synchroniser depth.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic serialClock,
  input  logic serialData,
  output logic risingEdge,
  output logic dataBit
);

  logic [SYNC_STAGES-1:0] clkSync;
  logic [SYNC_STAGES-1:0] dataSync;
  logic                   prevClk;

  // NOTE: sequential state uses non-blocking assignments so every stage samples the
  // previous stage's old value; blocking here would collapse the chain into one flop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clkSync  <= '0;
      dataSync <= '0;
      prevClk  <= 1'b0;
    end else begin
      clkSync  <= {clkSync[SYNC_STAGES-2:0], serialClock};
      dataSync <= {dataSync[SYNC_STAGES-2:0], serialData};
      prevClk  <= clkSync[SYNC_STAGES-1];
    end
  end

  assign risingEdge = clkSync[SYNC_STAGES-1] & ~prevClk;
  assign dataBit    = dataSync[SYNC_STAGES-1];

endmodule

// File: rtl/serial_frame_receiver.sv
// Receiving end of the serialClock/serialData link: shifts in MSB-first frames and hands them
// to the consumer through a one-entry holding buffer with overrun and timeout reporting.
module serial_frame_receiver
  import serial_frame_receiver_pkg::*;
#(
  parameter int WIDTH          = DEFAULT_WIDTH,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int SYNC_STAGES    = DEFAULT_SYNC_STAGES
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     serialClock,
  input  logic                     serialData,
  serial_frame_receiver_if.master  frameBus
);

  localparam int COUNT_W = $clog2(WIDTH + 1);
  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [COUNT_W-1:0] COUNT_LAST = COUNT_W'(WIDTH - 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  logic risingEdge;
  logic dataBit;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) syncEdge (
    .clock      (clock),
    .reset      (reset),
    .serialClock(serialClock),
    .serialData (serialData),
    .risingEdge (risingEdge),
    .dataBit    (dataBit)
  );

  rxStateT            state,    nextState;
  logic [WIDTH-1:0]   shiftReg, nextShift;
  logic [COUNT_W-1:0] bitCount, nextCount;
  logic [TIMER_W-1:0] timer,    nextTimer;
  logic               frameDone, nextDone;
  logic               frameErrorReg, nextError;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      shiftReg      <= '0;
      bitCount      <= '0;
      timer         <= '0;
      frameDone     <= 1'b0;
      frameErrorReg <= 1'b0;
    end else begin
      state         <= nextState;
      shiftReg      <= nextShift;
      bitCount      <= nextCount;
      timer         <= nextTimer;
      frameDone     <= nextDone;
      frameErrorReg <= nextError;
    end
  end

  always_comb begin
    // NOTE: every output of this block is defaulted before the case so no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    nextState = state;
    nextShift = shiftReg;
    nextCount = bitCount;
    nextTimer = timer;
    nextDone  = 1'b0;
    nextError = 1'b0;

    case (state)
      IDLE: begin
        nextTimer = '0;
        if (risingEdge) begin
          nextShift = {shiftReg[WIDTH-2:0], dataBit};
          nextCount = COUNT_W'(1);
          nextState = SHIFT;
        end
      end

      SHIFT: begin
        // An edge arriving in the timeout cycle is still taken as a data bit.
        if (risingEdge) begin
          nextShift = {shiftReg[WIDTH-2:0], dataBit};
          nextTimer = '0;
          if (bitCount == COUNT_LAST) begin
            nextDone  = 1'b1;
            nextCount = '0;
            nextState = IDLE;
          end else begin
            nextCount = bitCount + COUNT_W'(1);
          end
        end else if (timer == TIMER_LAST) begin
          nextError = 1'b1;
          nextShift = '0;
          nextCount = '0;
          nextTimer = '0;
          nextState = IDLE;
        end else begin
          nextTimer = timer + TIMER_W'(1);
        end
      end

      default: nextState = IDLE;
    endcase
  end

  logic [WIDTH-1:0] dataOutReg;
  logic             dataValidReg;
  logic             overrunReg;

  // Holding buffer: a completed frame loads when the slot is empty or being emptied this cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dataOutReg   <= '0;
      dataValidReg <= 1'b0;
      overrunReg   <= 1'b0;
    end else begin
      if (frameDone && (!dataValidReg || frameBus.dataAccept)) begin
        dataOutReg   <= shiftReg;
        dataValidReg <= 1'b1;
      end else if (dataValidReg && frameBus.dataAccept) begin
        dataValidReg <= 1'b0;
      end

      if (frameDone && dataValidReg && !frameBus.dataAccept) begin
        overrunReg <= 1'b1;
      end else if (frameBus.clearErrors) begin
        overrunReg <= 1'b0;
      end
    end
  end

  assign frameBus.dataOut    = dataOutReg;
  assign frameBus.dataValid  = dataValidReg;
  assign frameBus.overrun    = overrunReg;
  assign frameBus.frameError = frameErrorReg;

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Directed bench for serial_frame_receiver: table of frames plus hand-timed corner sequences.
module tb_serial_frame_receiver;
  import serial_frame_receiver_pkg::*;

  localparam int W = 8;

  logic clock       = 1'b0;
  logic reset       = 1'b1;
  logic serialClock = 1'b0;
  logic serialData  = 1'b0;

  serial_frame_receiver_if #(.WIDTH(W)) frameBus ();

  serial_frame_receiver #(
    .WIDTH         (W),
    .TIMEOUT_CYCLES(64),
    .SYNC_STAGES   (2)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .serialClock(serialClock),
    .serialData (serialData),
    .frameBus   (frameBus)
  );

  always #5 clock = ~clock;

  int checks      = 0;
  int failures    = 0;
  int errorPulses = 0;

  // Counts cycles with frameError high; a one-cycle pulse adds exactly one.
  always @(negedge clock) begin
    if (frameBus.frameError === 1'b1) errorPulses++;
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Called at a negedge: low phase with data set up, then raise serialClock at a negedge.
  task automatic riseBit(input logic b);
    serialClock = 1'b0;
    serialData  = b;
    repeat (4) @(negedge clock);
    serialClock = 1'b1;
  endtask

  task automatic fallAfterHigh();
    repeat (4) @(negedge clock);
    serialClock = 1'b0;
  endtask

  task automatic sendPrefix(input logic [W-1:0] frame, input int nBits);
    for (int i = 0; i < nBits; i++) begin
      riseBit(frame[W-1-i]);
      fallAfterHigh();
    end
  endtask

  task automatic sendFrame(input logic [W-1:0] frame);
    sendPrefix(frame, W);
  endtask

  task automatic pulseAccept();
    frameBus.dataAccept = 1'b1;
    @(negedge clock);
    frameBus.dataAccept = 1'b0;
  endtask

  task automatic pulseClear();
    frameBus.clearErrors = 1'b1;
    @(negedge clock);
    frameBus.clearErrors = 1'b0;
  endtask

  typedef struct {
    logic [W-1:0] frame;
    logic [W-1:0] expOut;
    logic         expOverrun;
    int           expLatency;
  } vectorT;

  vectorT vectors [6];

  initial begin
    int   latency;
    logic stable;
    int   base;

    vectors[0] = '{frame: 8'hA5, expOut: 8'hA5, expOverrun: 1'b0, expLatency: 3};
    vectors[1] = '{frame: 8'h76, expOut: 8'h76, expOverrun: 1'b0, expLatency: 3};
    vectors[2] = '{frame: 8'hC3, expOut: 8'hC3, expOverrun: 1'b0, expLatency: 3};
    vectors[3] = '{frame: 8'h00, expOut: 8'h00, expOverrun: 1'b0, expLatency: 3};
    vectors[4] = '{frame: 8'hFF, expOut: 8'hFF, expOverrun: 1'b0, expLatency: 3};
    vectors[5] = '{frame: 8'h81, expOut: 8'h81, expOverrun: 1'b0, expLatency: 3};

    frameBus.dataAccept  = 1'b0;
    frameBus.clearErrors = 1'b0;

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_dataOut", frameBus.dataOut, 0);
    check("rst_dataValid", frameBus.dataValid, 0);
    check("rst_overrun", frameBus.overrun, 0);
    check("rst_frameError", frameBus.frameError, 0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Table: single frame then back-to-back frames, each accepted once presented
    for (int i = 0; i < 6; i++) begin
      sendPrefix(vectors[i].frame, W - 1);
      riseBit(vectors[i].frame[0]);
      latency = -1;
      for (int k = 0; k < 10; k++) begin
        @(posedge clock);
        #1;
        if (frameBus.dataValid === 1'b1) begin
          latency = k;
          break;
        end
      end
      check($sformatf("vec%0d_latency", i), latency, vectors[i].expLatency);
      fallAfterHigh();
      check($sformatf("vec%0d_valid", i), frameBus.dataValid, 1);
      check($sformatf("vec%0d_dataOut", i), frameBus.dataOut, vectors[i].expOut);
      check($sformatf("vec%0d_overrun", i), frameBus.overrun, vectors[i].expOverrun);
      if (i == 0) begin
        stable = 1'b1;
        repeat (20) begin
          @(negedge clock);
          if (frameBus.dataValid !== 1'b1 || frameBus.dataOut !== vectors[i].expOut) stable = 1'b0;
        end
        check("vec0_hold20", stable, 1);
      end
      pulseAccept();
      check($sformatf("vec%0d_validAfterAccept", i), frameBus.dataValid, 0);
      check($sformatf("vec%0d_dataOutHeld", i), frameBus.dataOut, vectors[i].expOut);
    end
    check("table_noFrameError", errorPulses, 0);

    // Overrun: second frame dropped while the first is held
    sendFrame(8'h11);
    sendFrame(8'h22);
    check("ovr_dataOut", frameBus.dataOut, 8'h11);
    check("ovr_valid", frameBus.dataValid, 1);
    check("ovr_overrun", frameBus.overrun, 1);
    pulseClear();
    check("ovr_clearOverrun", frameBus.overrun, 0);
    check("ovr_clearDataOut", frameBus.dataOut, 8'h11);
    pulseAccept();
    check("ovr_drained", frameBus.dataValid, 0);

    // Accept in the exact cycle the second frame completes (cycle 3 after the last rising sample)
    sendFrame(8'h99);
    sendPrefix(8'h5A, W - 1);
    riseBit(1'b0);
    stable = 1'b1;
    repeat (3) begin
      @(negedge clock);
      if (frameBus.dataValid !== 1'b1) stable = 1'b0;
    end
    frameBus.dataAccept = 1'b1;
    @(negedge clock);
    frameBus.dataAccept = 1'b0;
    check("simul_validNeverDropped", stable, 1);
    check("simul_valid", frameBus.dataValid, 1);
    check("simul_dataOut", frameBus.dataOut, 8'h5A);
    check("simul_overrun", frameBus.overrun, 0);
    fallAfterHigh();
    pulseAccept();

    // Overrun set and clearErrors in the same cycle: set wins
    sendFrame(8'h33);
    sendPrefix(8'h44, W - 1);
    riseBit(1'b0);
    repeat (3) @(negedge clock);
    frameBus.clearErrors = 1'b1;
    @(negedge clock);
    frameBus.clearErrors = 1'b0;
    check("setWins_overrun", frameBus.overrun, 1);
    check("setWins_dataOut", frameBus.dataOut, 8'h33);
    fallAfterHigh();
    pulseClear();
    pulseAccept();

    // Timeout after 5 bits, then a clean frame
    base = errorPulses;
    sendPrefix(8'hB6, 5);
    repeat (55) @(negedge clock);
    check("to_noEarlyError", errorPulses - base, 0);
    repeat (15) @(negedge clock);
    check("to_onePulse", errorPulses - base, 1);
    check("to_valid", frameBus.dataValid, 0);
    sendFrame(8'h3C);
    check("to_nextDataOut", frameBus.dataOut, 8'h3C);
    check("to_nextValid", frameBus.dataValid, 1);
    check("to_noExtraPulse", errorPulses - base, 1);

    // Reset mid-frame with a full buffer: async clear, then a clean frame
    sendPrefix(8'hF0, 4);
    #2;
    reset = 1'b1;
    #1;
    check("rstMid_dataOut", frameBus.dataOut, 0);
    check("rstMid_valid", frameBus.dataValid, 0);
    check("rstMid_overrun", frameBus.overrun, 0);
    check("rstMid_frameError", frameBus.frameError, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    base = errorPulses;
    sendFrame(8'hE7);
    check("rstMid_nextDataOut", frameBus.dataOut, 8'hE7);
    check("rstMid_nextValid", frameBus.dataValid, 1);
    check("rstMid_nextOverrun", frameBus.overrun, 0);
    check("rstMid_noError", errorPulses - base, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
